// File: rtl/gate_pipe.sv
// gate_pipe: two-stage WIDTH-bit bitwise logic unit with valid/ready on both sides.
// Define GATE_PIPE_PARITY_EN to add a registered out_par (XOR-reduce of out).
module gate_pipe #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
`ifdef GATE_PIPE_PARITY_EN
  output logic             out_par,
`endif
  output logic [CNT_W-1:0] done_cnt
);

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [2:0]       op_q, op_d;
  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] res;
  logic             s1_load, s2_load;

  assign s2_load  = !s2_valid_q || out_ready;
  assign s1_load  = !s1_valid_q || s2_load;
  assign in_ready = s1_load;

  always_comb begin
    res = '0;
    unique case (op_q)
      3'b000: res = a_q & b_q;
      3'b001: res = a_q | b_q;
      3'b010: res = a_q ^ b_q;
      3'b011: res = ~(a_q & b_q);
      3'b100: res = ~(a_q | b_q);
      3'b101: res = ~(a_q ^ b_q);
      3'b110: res = ~a_q;
      3'b111: res = a_q;
      default: res = '0;
    endcase
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    a_d        = a_q;
    b_d        = b_q;
    op_d       = op_q;
    if (s1_load) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        a_d  = a;
        b_d  = b;
        op_d = op;
      end
    end
  end

  // out keeps its last value across bubbles
  always_comb begin
    s2_valid_d = s2_valid_q;
    out_d      = out_q;
    if (s2_load) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) out_d = res;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (s2_valid_q && out_ready && (cnt_q != {CNT_W{1'b1}}))
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      s2_valid_q <= 1'b0;
      out_q      <= '0;
      cnt_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      a_q        <= a_d;
      b_q        <= b_d;
      op_q       <= op_d;
      s2_valid_q <= s2_valid_d;
      out_q      <= out_d;
      cnt_q      <= cnt_d;
    end
  end

`ifdef GATE_PIPE_PARITY_EN
  logic par_q, par_d;

  always_comb begin
    par_d = par_q;
    if (s2_load && s1_valid_q) par_d = ^res;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) par_q <= 1'b0;
    else        par_q <= par_d;
  end

  assign out_par = par_q;
`endif

  assign out_valid = s2_valid_q;
  assign out       = out_q;
  assign done_cnt  = cnt_q;

endmodule
